// File: rtl/forward_hazard_unit.sv
// Forwarding selectors and load-use / branch hazard stall control for a 5-stage pipeline.
// Also keeps a saturating count of the cycles spent stalled or frozen.
//
// state      | meaning
// RUN        | normal issue; load-use and branch hazards are detected here
// LOAD_STALL | inserting the remaining load-use bubbles; cnt = bubbles left
module forward_hazard_unit #(
    parameter int AW       = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [AW-1:0]    rsID,
    input  logic [AW-1:0]    rtID,
    input  logic             useRsID,
    input  logic             useRtID,
    input  logic             branchID,
    input  logic [AW-1:0]    rsEX,
    input  logic [AW-1:0]    rtEX,
    input  logic [AW-1:0]    rdEX,
    input  logic             regWriteEX,
    input  logic             memReadEX,
    input  logic [AW-1:0]    rdMEM,
    input  logic             regWriteMEM,
    input  logic             memReadMEM,
    input  logic [AW-1:0]    rdWB,
    input  logic             regWriteWB,
    input  logic             memBusy,
    input  logic             clrStats,
    output logic [1:0]       dataSelectorID1,
    output logic [1:0]       dataSelectorID2,
    output logic [1:0]       dataSelectorEX1,
    output logic [1:0]       dataSelectorEX2,
    output logic             stallIF,
    output logic             stallID,
    output logic             flushEX,
    output logic             freeze,
    output logic [CNT_W-1:0] stallCycles
);

    typedef enum logic {
        RUN        = 1'b0,
        LOAD_STALL = 1'b1
    } stateT;

    localparam logic [1:0]       BUBBLES_AFTER = 2'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX       = '1;

    stateT      state, stateNext, curState;
    logic [1:0] cnt, cntNext;
    logic       loadUse, brHaz;
    logic       srcHitEX, srcHitMEM;

    // Register 0 is hardwired zero, so it never forwards and never hazards.
    function automatic logic match(input logic [AW-1:0] a, input logic [AW-1:0] d,
                                   input logic w);
        return w && (a == d) && (d != '0);
    endfunction

    function automatic logic [1:0] fwdSel(input logic [AW-1:0] src,
                                          input logic [AW-1:0] dMem, input logic wMem,
                                          input logic rdMem,
                                          input logic [AW-1:0] dWb, input logic wWb);
        logic [1:0] sel;
        sel = 2'd0;
        if (match(src, dMem, wMem) && !rdMem)
            sel = 2'd1;
        else if (match(src, dWb, wWb))
            sel = 2'd2;
        return sel;
    endfunction

    assign dataSelectorEX1 = fwdSel(rsEX, rdMEM, regWriteMEM, memReadMEM, rdWB, regWriteWB);
    assign dataSelectorEX2 = fwdSel(rtEX, rdMEM, regWriteMEM, memReadMEM, rdWB, regWriteWB);
    assign dataSelectorID1 = fwdSel(rsID, rdMEM, regWriteMEM, memReadMEM, rdWB, regWriteWB);
    assign dataSelectorID2 = fwdSel(rtID, rdMEM, regWriteMEM, memReadMEM, rdWB, regWriteWB);

    assign srcHitEX  = (useRsID && match(rsID, rdEX, regWriteEX)) ||
                       (useRtID && match(rtID, rdEX, regWriteEX));
    assign srcHitMEM = (useRsID && match(rsID, rdMEM, regWriteMEM)) ||
                       (useRtID && match(rtID, rdMEM, regWriteMEM));

    assign loadUse = memReadEX && srcHitEX;
    // A branch compared in ID needs ALU results one stage later, and load data two.
    assign brHaz   = branchID && ((srcHitEX && !memReadEX) || (srcHitMEM && memReadMEM));

    // While reset is held the outputs behave as if already back in RUN.
    assign curState = reset ? RUN : state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RUN;
            cnt   <= 2'd0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    always_comb begin
        stateNext = curState;
        cntNext   = cnt;
        stallIF   = 1'b0;
        stallID   = 1'b0;
        flushEX   = 1'b0;
        freeze    = 1'b0;
        if (memBusy) begin
            stallIF = 1'b1;
            stallID = 1'b1;
            freeze  = 1'b1;
        end else if (curState == LOAD_STALL) begin
            stallIF = 1'b1;
            stallID = 1'b1;
            flushEX = 1'b1;
            cntNext = cnt - 2'd1;
            if (cnt == 2'd1)
                stateNext = RUN;
        end else if (loadUse) begin
            stallIF = 1'b1;
            stallID = 1'b1;
            flushEX = 1'b1;
            if (LOAD_LAT > 1) begin
                stateNext = LOAD_STALL;
                cntNext   = BUBBLES_AFTER;
            end
        end else if (brHaz) begin
            stallIF = 1'b1;
            stallID = 1'b1;
            flushEX = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clrStats)
            stallCycles <= '0;
        else if (stallID && (stallCycles != CNT_MAX))
            stallCycles <= stallCycles + CNT_W'(1);
    end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Bench for forward_hazard_unit: three parameterisations share one stimulus stream and
// are checked every cycle against a bubble-count model, plus directed literal scenarios.
module tb_forward_hazard_unit;
    localparam int AW = 5;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset;
    logic [AW-1:0] rsID, rtID, rsEX, rtEX, rdEX, rdMEM, rdWB;
    logic          useRsID, useRtID, branchID, regWriteEX, memReadEX;
    logic          regWriteMEM, memReadMEM, regWriteWB, memBusy, clrStats;

    logic [1:0]  selID1 [3];
    logic [1:0]  selID2 [3];
    logic [1:0]  selEX1 [3];
    logic [1:0]  selEX2 [3];
    logic        stallIF [3];
    logic        stallID [3];
    logic        flushEX [3];
    logic        freeze [3];
    logic [15:0] scA, scB;
    logic [1:0]  scC;

    int total = 0;
    int bad   = 0;

    // u0: LOAD_LAT=1, u1: LOAD_LAT=3, u2: LOAD_LAT=4 with a 2-bit stall counter
    int lat [3]    = '{1, 3, 4};
    int maxCnt [3] = '{65535, 65535, 3};
    int bubLeft [3];
    int stCnt [3];
    bit started = 1'b0;

    forward_hazard_unit #(.AW(AW), .LOAD_LAT(1), .CNT_W(16)) u0 (
        .clock(clock), .reset(reset), .rsID(rsID), .rtID(rtID), .useRsID(useRsID),
        .useRtID(useRtID), .branchID(branchID), .rsEX(rsEX), .rtEX(rtEX), .rdEX(rdEX),
        .regWriteEX(regWriteEX), .memReadEX(memReadEX), .rdMEM(rdMEM),
        .regWriteMEM(regWriteMEM), .memReadMEM(memReadMEM), .rdWB(rdWB),
        .regWriteWB(regWriteWB), .memBusy(memBusy), .clrStats(clrStats),
        .dataSelectorID1(selID1[0]), .dataSelectorID2(selID2[0]),
        .dataSelectorEX1(selEX1[0]), .dataSelectorEX2(selEX2[0]),
        .stallIF(stallIF[0]), .stallID(stallID[0]), .flushEX(flushEX[0]),
        .freeze(freeze[0]), .stallCycles(scA));

    forward_hazard_unit #(.AW(AW), .LOAD_LAT(3), .CNT_W(16)) u1 (
        .clock(clock), .reset(reset), .rsID(rsID), .rtID(rtID), .useRsID(useRsID),
        .useRtID(useRtID), .branchID(branchID), .rsEX(rsEX), .rtEX(rtEX), .rdEX(rdEX),
        .regWriteEX(regWriteEX), .memReadEX(memReadEX), .rdMEM(rdMEM),
        .regWriteMEM(regWriteMEM), .memReadMEM(memReadMEM), .rdWB(rdWB),
        .regWriteWB(regWriteWB), .memBusy(memBusy), .clrStats(clrStats),
        .dataSelectorID1(selID1[1]), .dataSelectorID2(selID2[1]),
        .dataSelectorEX1(selEX1[1]), .dataSelectorEX2(selEX2[1]),
        .stallIF(stallIF[1]), .stallID(stallID[1]), .flushEX(flushEX[1]),
        .freeze(freeze[1]), .stallCycles(scB));

    forward_hazard_unit #(.AW(AW), .LOAD_LAT(4), .CNT_W(2)) u2 (
        .clock(clock), .reset(reset), .rsID(rsID), .rtID(rtID), .useRsID(useRsID),
        .useRtID(useRtID), .branchID(branchID), .rsEX(rsEX), .rtEX(rtEX), .rdEX(rdEX),
        .regWriteEX(regWriteEX), .memReadEX(memReadEX), .rdMEM(rdMEM),
        .regWriteMEM(regWriteMEM), .memReadMEM(memReadMEM), .rdWB(rdWB),
        .regWriteWB(regWriteWB), .memBusy(memBusy), .clrStats(clrStats),
        .dataSelectorID1(selID1[2]), .dataSelectorID2(selID2[2]),
        .dataSelectorEX1(selEX1[2]), .dataSelectorEX2(selEX2[2]),
        .stallIF(stallIF[2]), .stallID(stallID[2]), .flushEX(flushEX[2]),
        .freeze(freeze[2]), .stallCycles(scC));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit mt(logic [AW-1:0] a, logic [AW-1:0] d, logic w);
        return (w === 1'b1) && (a == d) && (d != 0);
    endfunction

    function automatic int expSel(logic [AW-1:0] a);
        if (mt(a, rdMEM, regWriteMEM) && !memReadMEM) return 1;
        if (mt(a, rdWB, regWriteWB)) return 2;
        return 0;
    endfunction

    function automatic bit srcHits(logic [AW-1:0] d, logic w);
        return (useRsID && mt(rsID, d, w)) || (useRtID && mt(rtID, d, w));
    endfunction

    function automatic bit expLoadUse();
        return memReadEX && srcHits(rdEX, regWriteEX);
    endfunction

    function automatic bit expBrHaz();
        return branchID && ((srcHits(rdEX, regWriteEX) && !memReadEX) ||
                            (srcHits(rdMEM, regWriteMEM) && memReadMEM));
    endfunction

    function automatic bit pending(int k);
        return !reset && (bubLeft[k] > 0);
    endfunction

    function automatic bit expStall(int k);
        return memBusy || pending(k) || expLoadUse() || expBrHaz();
    endfunction

    function automatic bit expFlush(int k);
        return !memBusy && (pending(k) || expLoadUse() || expBrHaz());
    endfunction

    function automatic logic [31:0] scOf(int k);
        if (k == 0) return {16'd0, scA};
        if (k == 1) return {16'd0, scB};
        return {30'd0, scC};
    endfunction

    always @(posedge clock) begin
        for (int k = 0; k < 3; k++) begin
            int nb;
            int nc;
            nb = bubLeft[k];
            nc = stCnt[k];
            if (reset) begin
                nb = 0;
                nc = 0;
            end else begin
                if (clrStats) nc = 0;
                else if (expStall(k) && nc < maxCnt[k]) nc = nc + 1;
                if (!memBusy) begin
                    if (nb > 0) nb = nb - 1;
                    else if (expLoadUse()) nb = lat[k] - 1;
                end
            end
            bubLeft[k] <= nb;
            stCnt[k]   <= nc;
        end
        started <= 1'b1;
    end

    always @(negedge clock) begin
        if (started) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("selID1[%0d]", k), 32'(selID1[k]), 32'(expSel(rsID)));
                check($sformatf("selID2[%0d]", k), 32'(selID2[k]), 32'(expSel(rtID)));
                check($sformatf("selEX1[%0d]", k), 32'(selEX1[k]), 32'(expSel(rsEX)));
                check($sformatf("selEX2[%0d]", k), 32'(selEX2[k]), 32'(expSel(rtEX)));
                check($sformatf("stallIF[%0d]", k), 32'(stallIF[k]), 32'(expStall(k)));
                check($sformatf("stallID[%0d]", k), 32'(stallID[k]), 32'(expStall(k)));
                check($sformatf("flushEX[%0d]", k), 32'(flushEX[k]), 32'(expFlush(k)));
                check($sformatf("freeze[%0d]", k), 32'(freeze[k]), 32'(memBusy));
                check($sformatf("stallCycles[%0d]", k), scOf(k), 32'(stCnt[k]));
            end
        end
    end

    task automatic idle();
        rsID = '0; rtID = '0; rsEX = '0; rtEX = '0; rdEX = '0; rdMEM = '0; rdWB = '0;
        useRsID = 0; useRtID = 0; branchID = 0; regWriteEX = 0; memReadEX = 0;
        regWriteMEM = 0; memReadMEM = 0; regWriteWB = 0; memBusy = 0; clrStats = 0;
    endtask

    task automatic nxt();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic setLoad5();
        rdEX = 5'd5; regWriteEX = 1; memReadEX = 1; useRsID = 1; rsID = 5'd5;
    endtask

    initial begin
        reset = 1;
        idle();
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst scA", 32'(scA), 0);
        check("rst stallID0", 32'(stallID[0]), 0);
        check("rst freeze0", 32'(freeze[0]), 0);

        // forwarding priority
        nxt(); reset = 0;
        rsEX = 5'd3; rdMEM = 5'd3; regWriteMEM = 1; rdWB = 5'd3; regWriteWB = 1;
        @(negedge clock);
        check("fwd mem", 32'(selEX1[0]), 1);
        nxt();
        rsEX = 5'd3; rdMEM = 5'd3; regWriteMEM = 1; memReadMEM = 1; rdWB = 5'd3; regWriteWB = 1;
        @(negedge clock);
        check("fwd wb", 32'(selEX1[0]), 2);
        nxt();
        regWriteMEM = 1; regWriteWB = 1; regWriteEX = 1;
        @(negedge clock);
        check("fwd r0", 32'(selEX1[0]), 0);

        // load-use bubbles for LOAD_LAT 1, 3 and 4
        nxt(); setLoad5();
        @(negedge clock);
        check("lu stall0", 32'(stallID[0]), 1);
        check("lu flush0", 32'(flushEX[0]), 1);
        check("lu stall1 c0", 32'(stallID[1]), 1);
        check("lu scA pre", 32'(scA), 0);
        nxt();
        @(negedge clock);
        check("lu stall0 c1", 32'(stallID[0]), 0);
        check("lu scA", 32'(scA), 1);
        check("lu stall1 c1", 32'(stallID[1]), 1);
        nxt();
        @(negedge clock);
        check("lu stall1 c2", 32'(stallID[1]), 1);
        nxt();
        @(negedge clock);
        check("lu stall1 c3", 32'(stallID[1]), 0);
        check("lu scB", 32'(scB), 3);
        check("lu stall2 c3", 32'(stallID[2]), 1);
        nxt();
        @(negedge clock);
        check("lu stall2 c4", 32'(stallID[2]), 0);
        check("lu scC sat", 32'(scC), 3);

        // branch after ALU producer, then forwarded from MEM
        nxt(); branchID = 1; useRsID = 1; rsID = 5'd7; rdEX = 5'd7; regWriteEX = 1;
        @(negedge clock);
        check("br stall", 32'(stallID[0]), 1);
        nxt(); branchID = 1; useRsID = 1; rsID = 5'd7; rdMEM = 5'd7; regWriteMEM = 1;
        @(negedge clock);
        check("br selID1", 32'(selID1[0]), 1);
        check("br nostall", 32'(stallID[0]), 0);

        // memBusy in the middle of a LOAD_STALL sequence
        nxt(); setLoad5();
        @(negedge clock);
        check("mb flush1 c0", 32'(flushEX[1]), 1);
        for (int i = 0; i < 4; i++) begin
            nxt(); memBusy = 1;
            @(negedge clock);
            check("mb freeze1", 32'(freeze[1]), 1);
            check("mb flush1", 32'(flushEX[1]), 0);
        end
        nxt();
        @(negedge clock);
        check("mb resume1", 32'(flushEX[1]), 1);
        nxt();
        @(negedge clock);
        check("mb resume2", 32'(flushEX[1]), 1);
        nxt();
        @(negedge clock);
        check("mb done", 32'(flushEX[1]), 0);
        repeat (2) nxt();

        // saturation and clear
        nxt(); clrStats = 1;
        repeat (5) begin nxt(); memBusy = 1; end
        nxt();
        @(negedge clock);
        check("sat scC", 32'(scC), 3);
        check("sat scA", 32'(scA), 5);
        nxt(); memBusy = 1; clrStats = 1;
        nxt();
        @(negedge clock);
        check("clr scA", 32'(scA), 0);
        check("clr scC", 32'(scC), 0);

        // reset aborts LOAD_STALL
        nxt(); setLoad5();
        nxt(); reset = 1;
        @(negedge clock);
        check("rst mid stall1", 32'(stallID[1]), 0);
        nxt(); reset = 0;
        @(negedge clock);
        check("rst after stall1", 32'(stallID[1]), 0);
        check("rst after scB", 32'(scB), 0);

        for (int i = 0; i < 3000; i++) begin
            @(posedge clock);
            #1;
            reset       = ($urandom_range(0, 99) == 0);
            rsID        = 5'($urandom_range(0, 7));
            rtID        = 5'($urandom_range(0, 7));
            rsEX        = 5'($urandom_range(0, 7));
            rtEX        = 5'($urandom_range(0, 7));
            rdEX        = 5'($urandom_range(0, 7));
            rdMEM       = 5'($urandom_range(0, 7));
            rdWB        = 5'($urandom_range(0, 7));
            useRsID     = 1'($urandom_range(0, 1));
            useRtID     = 1'($urandom_range(0, 1));
            branchID    = ($urandom_range(0, 3) == 0);
            regWriteEX  = 1'($urandom_range(0, 1));
            memReadEX   = 1'($urandom_range(0, 1));
            regWriteMEM = 1'($urandom_range(0, 1));
            memReadMEM  = 1'($urandom_range(0, 1));
            regWriteWB  = 1'($urandom_range(0, 1));
            memBusy     = ($urandom_range(0, 99) < 15);
            clrStats    = ($urandom_range(0, 99) < 3);
        end
        @(posedge clock);
        #1;
        @(negedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/forward_hazard_unit.md
FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 Parameter AW, default 5, register-address width.
REQ-002 Parameter LOAD_LAT, default 1, legal 1..4: bubble cycles inserted per load-use hazard.
REQ-003 Parameter CNT_W, default 16, width of the stall statistics counter.
REQ-004 Ports SHALL be, one per line:
 clock  in  1  single clock, rising edge
 reset  in  1  synchronous, active-high
 rsID, rtID  in  AW  ID-stage source registers
 useRsID, useRtID  in  1  ID instruction actually reads rs/rt
 branchID  in  1  ID instruction is a branch compared in ID
 rsEX, rtEX, rdEX  in  AW  EX-stage sources/destination
 regWriteEX, memReadEX  in  1  EX writes a register / is a load
 rdMEM  in  AW; regWriteMEM, memReadMEM  in  1  MEM-stage destination info
 rdWB  in  AW; regWriteWB  in  1  WB-stage destination info
 memBusy  in  1  data memory not ready; whole pipeline must freeze
 clrStats  in  1  clears stall counter
 dataSelectorID1, dataSelectorID2  out  2  ID operand source: 0 regfile, 1 MEM, 2 WB
 dataSelectorEX1, dataSelectorEX2  out  2  EX operand source: 0 ID/EX latch, 1 MEM, 2 WB
 stallIF, stallID  out  1  hold PC and IF/ID
 flushEX  out  1  load bubble into ID/EX
 freeze  out  1  hold all pipeline registers
 stallCycles  out  CNT_W  saturating count of stall/freeze cycles

Function
REQ-005 "Match(a, d, w)" SHALL mean w==1 and a==d and d!=0; register 0 is never forwarded or hazarded.
REQ-006 dataSelectorEXn: 1 if Match(srcEX, rdMEM, regWriteMEM) and memReadMEM==0; else 2 if Match(srcEX, rdWB, regWriteWB); else 0. MEM has priority over WB.
REQ-007 dataSelectorIDn: same rule with rsID/rtID; combinational, valid in every state, including freeze.
REQ-008 loadUse = memReadEX and ((useRsID and Match(rsID, rdEX, regWriteEX)) or (useRtID and Match(rtID, rdEX, regWriteEX))).
REQ-009 brHaz = branchID and (((useRsID/useRtID source matches rdEX via Match with regWriteEX) and memReadEX==0) or (source matches rdMEM via Match with regWriteMEM and memReadMEM==1)).
REQ-010 FSM states RUN and LOAD_STALL, with a 2-bit remaining-bubble counter cnt.
REQ-011 Priority each cycle: memBusy > LOAD_STALL state > loadUse > brHaz > none.
REQ-012 memBusy==1: freeze=1, stallIF=stallID=1, flushEX=0; state and cnt SHALL hold unchanged.
REQ-013 RUN, loadUse, memBusy==0: stallIF=stallID=flushEX=1 this cycle (zero latency); if LOAD_LAT>1 next state LOAD_STALL with cnt=LOAD_LAT-1, else remain RUN.
REQ-014 LOAD_STALL, memBusy==0: stallIF=stallID=flushEX=1; cnt decrements; cnt==1 returns to RUN next cycle.
REQ-015 RUN, brHaz, no loadUse: stallIF=stallID=flushEX=1 for that cycle only; re-evaluated next cycle, so a load producer yields loadUse bubbles followed by one brHaz bubble.
REQ-016 RUN, no hazard: stallIF=stallID=flushEX=freeze=0.
REQ-017 stallCycles increments by 1 on every cycle where stallID==1, saturates at 2^CNT_W-1; clrStats==1 loads 0 and overrides the increment.

Reset
REQ-018 reset==1 at a rising edge SHALL force state RUN, cnt=0, stallCycles=0, overriding memBusy and clrStats; mid-LOAD_STALL reset aborts the remaining bubbles.
REQ-019 While reset==1, stall outputs follow the combinational rules from state RUN; forwarding selectors stay combinational.

Verification
REQ-020 EX rs=3, MEM rd=3 regWrite=1, WB rd=3 regWrite=1 -> dataSelectorEX1=1; MEM memRead=1 instead -> 2; rs=0 with all dests 0 -> 0.
REQ-021 LOAD_LAT=1: load rd=5 in EX, ID useRs rs=5 -> exactly one cycle stallID=flushEX=1, stallCycles 0->1; LOAD_LAT=3 -> three consecutive stall cycles, stallCycles=3.
REQ-022 Branch in ID reading r7, ALU rd=7 in EX -> one stall; next cycle r7 in MEM -> dataSelectorID1=1, no stall.
REQ-023 memBusy=1 for 4 cycles during LOAD_STALL (LOAD_LAT=3, cnt=2) -> freeze=1, flushEX=0 for 4 cycles, then 2 remaining bubbles resume.
REQ-024 CNT_W=2, stall 5 cycles -> stallCycles saturates at 3; clrStats with simultaneous stall -> 0; reset mid-LOAD_STALL -> RUN next cycle, stallCycles=0.
